regfile_read_arbiter: RTL
=========================

REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of read requesters (2..4).
REQ-002 SHALL have parameter DW, default 16, register width.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester read request.
REQ-006 SHALL have port req_addr, input, NREQ x 3, per-requester register index R0..R7.
REQ-007 SHALL have port req_ready, output, NREQ, one-hot grant; transfer when req_valid[i] & req_ready[i].
REQ-008 SHALL have port wr_en, input, 1, register write strobe.
REQ-009 SHALL have port wr_addr, input, 3, write index.
REQ-010 SHALL have port wr_data, input, DW, write data.
REQ-011 SHALL have port scan_start, input, 1, debug pulse requesting a full R0..R7 dump.
REQ-012 SHALL have port scan_busy, output, 1, high while a scan runs.
REQ-013 SHALL have port rsp_valid, output, 1, read data valid, one-cycle pulse per transfer.
REQ-014 SHALL have port rsp_id, output, 3, requester index of the response; value NREQ marks a scan response.
REQ-015 SHALL have port rsp_addr, output, 3, register index of the response.
REQ-016 SHALL have port rsp_data, output, DW, read data.

Function
REQ-017 SHALL hold an internal 8 x DW register file; wr_en writes wr_data to wr_addr at the clock edge, with no arbitration and priority over nothing.
REQ-018 SHALL expose one shared read port, with at most one read accepted per cycle.
REQ-019 SHALL be a two-state FSM: ARB and SCAN.
REQ-020 In ARB: req_ready SHALL be combinational, one-hot, and given to the first valid requester at or after rr_ptr, wrapping modulo NREQ; all-zero when no request is valid.
REQ-021 On an accepted transfer from requester g: rr_ptr SHALL become (g+1) mod NREQ; rr_ptr SHALL be unchanged when there is no transfer.
REQ-022 Read latency SHALL be exactly 1 cycle: rsp_valid/rsp_id/rsp_addr/rsp_data are registered and valid in the cycle after acceptance; rsp_valid is low otherwise.
REQ-023 rsp_data SHALL be the register contents at the acceptance edge, i.e. before any same-cycle write unless the bypass feature is enabled (REQ-033).
REQ-024 scan_start in ARB SHALL move the FSM to SCAN on the next edge, with scan_start winning over requesters: req_ready is zero in that cycle.
REQ-025 In SCAN: req_ready SHALL be all-zero, scan_busy SHALL be 1, and the FSM SHALL issue reads of index 0..7 on 8 consecutive cycles, each answered 1 cycle later with rsp_id=NREQ and rsp_addr equal to the index.
REQ-026 After issuing index 7 the FSM SHALL return to ARB; scan_busy SHALL drop in the same cycle that ARB is re-entered.
REQ-027 scan_start while in SCAN SHALL be ignored (no restart, no queueing).
REQ-028 rr_ptr SHALL be preserved across a scan.
REQ-029 A requester holding req_valid without ready SHALL keep its request; the arbiter never drops a request, and requests are not sticky (a deasserted valid is forgotten).

Reset
REQ-030 With Reset_n=0 at an edge: FSM=ARB, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_addr=0, rsp_data=0, scan_busy=0, all 8 registers=0.
REQ-031 Reset mid-scan SHALL abort the scan with no further scan responses; a response pending from the previous cycle SHALL be suppressed.
REQ-032 req_ready SHALL be all-zero while Reset_n=0.

Configuration
REQ-033 Macro REGARB_WR_BYPASS_EN: when defined, a read accepted in the same cycle as wr_en to the same index SHALL return wr_data; when undefined, it SHALL return the old value (REQ-023).

Structure
REQ-034 Package regarb_pkg SHALL hold the FSM state enum (ARB, SCAN), the register count constant (8), and the index width constant (3).
REQ-035 Round-robin grant logic SHALL be sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-036 Write R3=16'h1234; next cycle req0 reads R3 -> req_ready=001, next cycle rsp_valid=1, rsp_id=0, rsp_data=16'h1234.
REQ-037 All three requesters valid continuously with rr_ptr=0 -> grants 001,010,100,001 on successive cycles.
REQ-038 Registers Rn=16'h0100+n, pulse scan_start -> 8 responses with rsp_id=3, rsp_addr 0..7, data 16'h0100..16'h0107; req_ready=000 for 9 cycles (the start cycle plus 8 issue cycles).
REQ-039 Same-cycle wr_en R5=16'hBEEF (old 16'h0005) and read R5 -> 16'hBEEF with REGARB_WR_BYPASS_EN defined, 16'h0005 without it.
REQ-040 Reset_n=0 on the 4th scan cycle -> no further rsp_valid, scan_busy=0, and a subsequent read of any register returns 16'h0000.
REQ-041 req1 valid alone with rr_ptr=2 -> grant 010, and rr_ptr becomes 2.

Source files
------------

// File: rtl/regarb_pkg.sv
// Shared types and constants for the register-file read arbiter.
package regarb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int unsigned NREGS = 8;
  localparam int unsigned IDXW  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping modulo NREQ; all-zero when nothing requests.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

  // Search distances 0..NREQ-1 from ptr and grant the nearest active request.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((i + NREQ - 32'(ptr)) % NREQ) == k)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Register file (8 x DW) with one shared read port arbitrated round-robin
// between NREQ requesters, plus a debug scan that dumps R0..R7.
// Optional macro REGARB_WR_BYPASS_EN: a read accepted in the same cycle as a
// write to the same index returns the write data instead of the old value.
module regfile_read_arbiter
  import regarb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IDXW-1:0] req_addr,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wr_en,
  input  logic [IDXW-1:0]      wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [IDXW-1:0]      rsp_addr,
  output logic [DW-1:0]        rsp_data
);

  state_t            state, state_n;
  logic [1:0]        rr_ptr, rr_ptr_n;
  logic [IDXW-1:0]   scan_idx, scan_idx_n;
  logic [DW-1:0]     regs [NREGS];
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ready;
  logic              rd_en;
  logic [IDXW-1:0]   rd_addr;
  logic [2:0]        rd_id;
  logic [1:0]        gidx;
  logic [DW-1:0]     rd_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Next-state, grant gating and read-port selection.
  always_comb begin
    state_n    = state;
    scan_idx_n = scan_idx;
    rr_ptr_n   = rr_ptr;
    ready      = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    rd_id      = '0;
    gidx       = '0;
    case (state)
      ARB: begin
        if (scan_start) begin
          state_n    = SCAN;
          scan_idx_n = '0;
        end else begin
          ready = grant;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              gidx    = 2'(i);
              rd_addr = req_addr[i*IDXW +: IDXW];
            end
          end
          if (|grant) begin
            rd_en    = 1'b1;
            rd_id    = {1'b0, gidx};
            rr_ptr_n = (gidx == 2'(NREQ - 1)) ? 2'd0 : gidx + 2'd1;
          end
        end
      end
      SCAN: begin
        rd_en      = 1'b1;
        rd_addr    = scan_idx;
        rd_id      = 3'(NREQ);
        scan_idx_n = scan_idx + 3'd1;
        if (scan_idx == 3'(NREGS - 1)) state_n = ARB;
      end
      default: state_n = ARB;
    endcase
    if (!Reset_n) ready = '0;
  end

  // Shared read port, optionally forwarding same-cycle write data.
  always_comb begin
    rd_data = regs[rd_addr];
`ifdef REGARB_WR_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
`endif
  end

  assign req_ready = ready;
  assign scan_busy = (state == SCAN);

  // State, pointer, register file and registered response.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= ARB;
      rr_ptr    <= '0;
      scan_idx  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      scan_idx  <= scan_idx_n;
      rsp_valid <= rd_en;
      if (rd_en) begin
        rsp_id   <= rd_id;
        rsp_addr <= rd_addr;
        rsp_data <= rd_data;
      end
      if (wr_en) regs[wr_addr] <= wr_data;
    end
  end

endmodule
